// File: rtl/pfb_bank_scheduler_if.sv
// ---------------------------------------------------------------------------
// pfb_bank_scheduler_if
//   Bundles the PFB word stream, the BRAM write port, the packetizer
//   hand-off and the status outputs of pfb_bank_scheduler.
//
//   Signals (direction seen from the scheduler, i.e. the slave modport):
//     in_valid, in_last  in   PFB word strobe and end-of-frame marker
//     wen, waddr         out  BRAM write enable / {bank, word pointer}
//     bramrdy            out  a full bank is handed to the packetizer
//     rd_bank, rd_len    out  handed bank index and its word count
//     done               in   packetizer finished reading the handed bank
//     clr                out  one-cycle pulse releasing a bank
//     overflow           out  sticky frame dropped/truncated flag
//     drop_cnt           out  saturating dropped-frame counter
//
//   master: the PFB source / packetizer side.  slave: the scheduler.
// ---------------------------------------------------------------------------
interface pfb_bank_scheduler_if #(
  parameter int ADDR_W = 9
);
  logic              in_valid;
  logic              in_last;
  logic              wen;
  logic [ADDR_W:0]   waddr;
  logic              bramrdy;
  logic              rd_bank;
  logic [ADDR_W:0]   rd_len;
  logic              done;
  logic              clr;
  logic              overflow;
  logic [15:0]       drop_cnt;

  modport master (
    output in_valid, in_last, done,
    input  wen, waddr, bramrdy, rd_bank, rd_len, clr, overflow, drop_cnt
  );

  modport slave (
    input  in_valid, in_last, done,
    output wen, waddr, bramrdy, rd_bank, rd_len, clr, overflow, drop_cnt
  );
endinterface

// File: rtl/pfb_bank_scheduler.sv
// ---------------------------------------------------------------------------
// pfb_bank_scheduler
//   Ping-pong scheduler for two BRAM banks holding PFB frames. The write FSM
//   streams words into the current write bank and closes it on the last
//   word of a frame or when the bank is full; the read FSM hands closed
//   banks to the packetizer in write order and releases them on done.
//
//   Ports:
//     clk    in  sole clock, rising edge
//     rst_n  in  synchronous active-low reset
//     bus    pfb_bank_scheduler_if.slave (stream, BRAM write, hand-off,
//            status); see the interface file for the signal list.
//
//   Parameter ADDR_W: per-bank word-address width (2**ADDR_W words/bank).
// ---------------------------------------------------------------------------
module pfb_bank_scheduler #(
  parameter int ADDR_W = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pfb_bank_scheduler_if.slave   bus
);

  localparam logic [ADDR_W-1:0] WPTR_MAX = '1;
  localparam logic [ADDR_W-1:0] WPTR_ONE = 1;
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;

  typedef enum logic [1:0] {W_FILL, W_WAIT, W_DROP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_BUSY, R_CLR}  rstate_t;

  wstate_t                wstate_q, wstate_d;
  rstate_t                rstate_q, rstate_d;
  logic                   wbank_q, wbank_d;
  logic                   rbank_q, rbank_d;
  logic [ADDR_W-1:0]      wptr_q, wptr_d;
  logic [1:0]             full_q, full_set, full_clr;
  logic [1:0][ADDR_W:0]   len_q, len_d;
  logic                   bramrdy_q, bramrdy_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [ADDR_W:0]        rd_len_q, rd_len_d;
  logic                   overflow_q, overflow_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;
  logic                   wen_c;
  logic                   clr_c;

  // Write FSM: next state and zero-latency BRAM write strobe.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wstate_d   = wstate_q;
    wbank_d    = wbank_q;
    wptr_d     = wptr_q;
    len_d      = len_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    full_set   = '0;
    wen_c      = 1'b0;

    case (wstate_q)
      W_FILL: begin
        if (bus.in_valid) begin
          wen_c = 1'b1;
          if (bus.in_last || wptr_q == WPTR_MAX) begin
            full_set[wbank_q] = 1'b1;
            len_d[wbank_q]    = {1'b0, wptr_q} + LEN_ONE;
            wbank_d           = ~wbank_q;
            wptr_d            = '0;
            if (!bus.in_last) begin
              // Bank ran out mid-frame: keep what fits, discard the rest.
              overflow_d = 1'b1;
              wstate_d   = W_DROP;
            end else if (full_q[~wbank_q]) begin
              wstate_d = W_WAIT;
            end
          end else begin
            wptr_d = wptr_q + WPTR_ONE;
          end
        end
      end
      W_WAIT: begin
        if (bus.in_valid) begin
          // First word of a frame with no free bank: the whole frame goes.
          overflow_d = 1'b1;
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          if (!bus.in_last) wstate_d = W_DROP;
        end else if (!full_q[wbank_q]) begin
          // Only resume between frames so a bank never starts mid-frame.
          wstate_d = W_FILL;
        end
      end
      W_DROP: begin
        if (bus.in_valid && bus.in_last)
          wstate_d = full_q[wbank_q] ? W_WAIT : W_FILL;
      end
      default: wstate_d = W_FILL;
    endcase
  end

  // Read FSM: hand full banks to the packetizer in strict alternation.
  always_comb begin
    rstate_d  = rstate_q;
    rbank_d   = rbank_q;
    bramrdy_d = bramrdy_q;
    rd_bank_d = rd_bank_q;
    rd_len_d  = rd_len_q;
    full_clr  = '0;
    clr_c     = 1'b0;

    case (rstate_q)
      R_IDLE: begin
        if (full_q[rbank_q]) begin
          rstate_d  = R_BUSY;
          bramrdy_d = 1'b1;
          rd_bank_d = rbank_q;
          rd_len_d  = len_q[rbank_q];
        end
      end
      R_BUSY: begin
        if (bus.done) begin
          rstate_d  = R_CLR;
          bramrdy_d = 1'b0;
        end
      end
      R_CLR: begin
        clr_c             = 1'b1;
        full_clr[rbank_q] = 1'b1;
        rbank_d           = ~rbank_q;
        rstate_d          = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the length table is only two entries, so it is reset along with the
  // rest of the state rather than left to a BRAM-style uninitialised array.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate_q   <= W_FILL;
      rstate_q   <= R_IDLE;
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      wptr_q     <= '0;
      full_q     <= '0;
      len_q      <= '0;
      bramrdy_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_len_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wstate_q   <= wstate_d;
      rstate_q   <= rstate_d;
      wbank_q    <= wbank_d;
      rbank_q    <= rbank_d;
      wptr_q     <= wptr_d;
      // Set and clear never target the same bank: the write side only
      // closes a bank that was free, the read side only clears a full one.
      full_q     <= (full_q | full_set) & ~full_clr;
      len_q      <= len_d;
      bramrdy_q  <= bramrdy_d;
      rd_bank_q  <= rd_bank_d;
      rd_len_q   <= rd_len_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Suppress BRAM writes while reset is asserted; the state is being
  // discarded at that edge anyway.
  assign bus.wen      = wen_c & rst_n;
  assign bus.waddr    = {wbank_q, wptr_q};
  assign bus.bramrdy  = bramrdy_q;
  assign bus.rd_bank  = rd_bank_q;
  assign bus.rd_len   = rd_len_q;
  assign bus.clr      = clr_c;
  assign bus.overflow = overflow_q;
  assign bus.drop_cnt = drop_cnt_q;

endmodule
